// File: rtl/avr_regfile_pkg.sv
// Shared types and defaults for the AVR register file with debugger access.
package avr_regfile_pkg;

  // Debug/clear sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBG   = 2'd1,
    CLEAR = 2'd2
  } fsm_state_t;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_PTR_BASE = 26;

  // Widest register address the pair helper understands
  localparam int PAIR_ADDR_MAX_W = 16;

  // Even (low-byte) address of the register pair containing addr
  function automatic logic [PAIR_ADDR_MAX_W-1:0] pair_base(input logic [PAIR_ADDR_MAX_W-1:0] addr);
    return {addr[PAIR_ADDR_MAX_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/avr_regfile_dbg_fsm.sv
// Sequencer for debugger accesses and the clear-all sweep.
module avr_regfile_dbg_fsm
  import avr_regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic              dbg_req,
  input  logic              dbg_conflict,
  output logic              dbg_go,
  output logic              dbg_ack,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  fsm_state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Clear index restarts on entry to CLEAR and advances once per clear cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 idx_q <= '0;
    else if (state_q == IDLE && state_d == CLEAR) idx_q <= '0;
    else if (state_q == CLEAR)                  idx_q <= idx_q + 1'b1;
  end

  // Next state; clear beats debug, and a debug access waits out any colliding core write
  always_comb begin
    state_d = state_q;
    dbg_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
        end else if (dbg_req && !dbg_conflict) begin
          state_d = DBG;
          dbg_go  = 1'b1;
        end
      end
      DBG:     state_d = IDLE;
      CLEAR:   if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    dbg_ack = (state_q == DBG);
    busy    = (state_q == CLEAR);
    clr_we  = (state_q == CLEAR);
    clr_idx = idx_q;
  end

endmodule

// File: rtl/avr_regfile_dbg.sv
// AVR general-purpose register file: two read ports, byte/pair write,
// X/Y/Z pointers, optional write-through bypass, debugger port and clear-all.
module avr_regfile_dbg
  import avr_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int PTR_BASE = DEF_PTR_BASE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_pair,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   wr_data_hi,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  input  logic [ADDR_W-1:0]   rd2_addr,
  output logic [DATA_W-1:0]   rd2_data,
  output logic [2*DATA_W-1:0] x_ptr,
  output logic [2*DATA_W-1:0] y_ptr,
  output logic [2*DATA_W-1:0] z_ptr,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_ack,
  input  logic                clr_start,
  output logic                busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREG_CMP = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              dbg_go, clr_we, dbg_conflict;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] pair_lo, pair_hi, lo_addr, dbg_pair;
  logic              lo_we, hi_we;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREG_CMP);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  avr_regfile_dbg_fsm #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_start   (clr_start),
    .dbg_req     (dbg_req),
    .dbg_conflict(dbg_conflict),
    .dbg_go      (dbg_go),
    .dbg_ack     (dbg_ack),
    .busy        (busy),
    .clr_we      (clr_we),
    .clr_idx     (clr_idx)
  );

  // Core write decode: pair beats byte, out-of-range bytes and clear-time writes are dropped
  always_comb begin
    pair_lo      = ADDR_W'(pair_base(PAIR_ADDR_MAX_W'(wr_addr)));
    pair_hi      = {pair_lo[ADDR_W-1:1], 1'b1};
    lo_addr      = wr_pair ? pair_lo : wr_addr;
    lo_we        = !busy && (wr_en || wr_pair) && in_range(lo_addr);
    hi_we        = !busy && wr_pair && in_range(pair_hi);
    dbg_pair     = ADDR_W'(pair_base(PAIR_ADDR_MAX_W'(dbg_addr)));
    dbg_conflict = (wr_pair && (pair_lo == dbg_pair)) ||
                   (wr_en && !wr_pair && (wr_addr == dbg_addr));
  end

  // Register array; clear sweep, core writes and debugger writes never hit the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[IDX_W'(i)] <= '0;
    end else if (clr_we) begin
      regs[idx(clr_idx)] <= '0;
    end else begin
      if (lo_we) regs[idx(lo_addr)] <= wr_data;
      if (hi_we) regs[idx(pair_hi)] <= wr_data_hi;
      if (dbg_go && dbg_we && in_range(dbg_addr)) regs[idx(dbg_addr)] <= dbg_wdata;
    end
  end

  // Debugger read data is captured as the access is granted and held through the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_rdata <= '0;
    else if (dbg_go && !dbg_we)
      dbg_rdata <= in_range(dbg_addr) ? regs[idx(dbg_addr)] : '0;
  end

  // Read port 1 with optional same-cycle forwarding of core write data
  always_comb begin
    rd1_data = '0;
    if (in_range(rd1_addr)) rd1_data = regs[idx(rd1_addr)];
    if (BYPASS != 0) begin
      if (lo_we && rd1_addr == lo_addr) rd1_data = wr_data;
      if (hi_we && rd1_addr == pair_hi) rd1_data = wr_data_hi;
    end
  end

  // Read port 2 with optional same-cycle forwarding of core write data
  always_comb begin
    rd2_data = '0;
    if (in_range(rd2_addr)) rd2_data = regs[idx(rd2_addr)];
    if (BYPASS != 0) begin
      if (lo_we && rd2_addr == lo_addr) rd2_data = wr_data;
      if (hi_we && rd2_addr == pair_hi) rd2_data = wr_data_hi;
    end
  end

  // Pointer pairs straight from the array, never forwarded
  always_comb begin
    x_ptr = {regs[IDX_W'(PTR_BASE + 1)], regs[IDX_W'(PTR_BASE)]};
    y_ptr = {regs[IDX_W'(PTR_BASE + 3)], regs[IDX_W'(PTR_BASE + 2)]};
    z_ptr = {regs[IDX_W'(PTR_BASE + 5)], regs[IDX_W'(PTR_BASE + 4)]};
  end

endmodule
